// File: rtl/dvi_pkg.sv
// Shared DVI test-pattern definitions used by both the pattern generator and checker.
package dvi_pkg;

    localparam int PIX_W           = 6;
    localparam int X_W             = 11;
    localparam int Y_W             = 10;
    localparam int PAT_Y_CHECK_END = 200;
    localparam int PAT_Y_SPLIT_END = 400;
    localparam int PAT_X_SPLIT     = 512;

    typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} chk_state_e;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/dvi_pattern_expect.sv
// Combinational reference for the DVI test pattern: (X, Y, frame_lsb) -> expected RGB.
module dvi_pattern_expect
    import dvi_pkg::*;
(
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic [PIX_W-1:0] frame_lsb,
    output rgb_t             exp_pix
);

    logic [PIX_W-1:0] x_lo;
    logic [PIX_W-1:0] x_f;
    logic [PIX_W-1:0] y_f;

    always_comb begin
        x_lo    = x[PIX_W-1:0];
        x_f     = x_lo + frame_lsb;
        y_f     = y[PIX_W-1:0] + frame_lsb;
        exp_pix = '0;
        if (y < Y_W'(PAT_Y_CHECK_END)) begin
            if (x[0] ^ y[0]) begin
                exp_pix = '1;
            end
        end else if (y < Y_W'(PAT_Y_SPLIT_END)) begin
            if (x < X_W'(PAT_X_SPLIT)) begin
                exp_pix.g = x_f;
            end else begin
                exp_pix.r = y_f;
            end
        end else begin
            exp_pix.r = x_lo;
            exp_pix.g = x_lo;
            exp_pix.b = y_f;
        end
    end

endmodule

// File: rtl/dvi_pattern_checker.sv
// Receive-side DVI test-pattern checker: tracks X/Y, locks to the generator frame
// counter and counts pixel mismatches and geometry violations.
module dvi_pattern_checker
    import dvi_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 1024,
    parameter int unsigned V_ACTIVE    = 768,
    parameter bit          VS_POL      = 1'b1,
    parameter int unsigned LOSS_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_de,
    input  logic             pix_vs,
    input  logic [PIX_W-1:0] pix_r,
    input  logic [PIX_W-1:0] pix_g,
    input  logic [PIX_W-1:0] pix_b,
    input  logic             clear,
    output logic             locked,
    output logic             frame_done,
    output logic [19:0]      frame_err_cnt,
    output logic [31:0]      total_err_cnt,
    output logic             geom_err,
    output logic [X_W-1:0]   first_err_x,
    output logic [Y_W-1:0]   first_err_y
);

    logic             de1_q, de2_q, vs1_q, vs2_q;
    rgb_t             pix1_q;
    logic [X_W-1:0]   x_q, x_d, fx_q, fx_d;
    logic [Y_W-1:0]   y_q, y_d, fy_q, fy_d;
    chk_state_e       state_q, state_d;
    logic [PIX_W-1:0] flsb_q, flsb_d;
    logic             skip_q, skip_d;
    logic [19:0]      run_q, run_d, ferr_q, ferr_d, run_inc;
    logic [31:0]      total_q, total_d;
    logic             geom_q, geom_d, fvalid_q, fvalid_d, fd_q, fd_d;
    logic             de_fall, vs_rise, mismatch;
    rgb_t             exp_pix;

    dvi_pattern_expect u_expect (
        .x         (x_q),
        .y         (y_q),
        .frame_lsb (flsb_q),
        .exp_pix   (exp_pix)
    );

    always_comb begin
        de_fall  = de2_q & ~de1_q;
        vs_rise  = vs1_q & ~vs2_q;
        mismatch = (state_q == LOCKED) && de1_q && (pix1_q != exp_pix);
        run_inc  = (mismatch && (run_q != '1)) ? run_q + 1'b1 : run_q;
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        state_d  = state_q;
        flsb_d   = flsb_q;
        skip_d   = skip_q;
        run_d    = run_inc;
        ferr_d   = ferr_q;
        total_d  = total_q;
        geom_d   = geom_q;
        fvalid_d = fvalid_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        fd_d     = 1'b0;

        if (de1_q) begin
            x_d = x_q + 1'b1;
        end
        if (de_fall) begin
            x_d = '0;
            y_d = y_q + 1'b1;
        end
        if (vs_rise) begin
            y_d = '0;
        end

        // clear lands first so a coincident mismatch is still recorded
        if (clear) begin
            total_d  = '0;
            geom_d   = 1'b0;
            fvalid_d = 1'b0;
            fx_d     = '0;
            fy_d     = '0;
        end
        if (mismatch) begin
            if (total_d != '1) begin
                total_d = total_d + 1'b1;
            end
            if (!fvalid_d) begin
                fvalid_d = 1'b1;
                fx_d     = x_q;
                fy_d     = y_q;
            end
        end

        unique case (state_q)
            SEEK: begin
                if (vs_rise) begin
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (de1_q && (x_q == '0) && (y_q == Y_W'(PAT_Y_CHECK_END))) begin
                    flsb_d  = pix1_q.g;
                    skip_d  = 1'b1;
                    run_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (de_fall && (x_q != X_W'(H_ACTIVE))) begin
                    geom_d = 1'b1;
                end
                if (vs_rise) begin
                    // the partial frame in which lock was acquired has no valid height
                    if (!skip_q && (y_q != Y_W'(V_ACTIVE))) begin
                        geom_d = 1'b1;
                    end
                    skip_d = 1'b0;
                    flsb_d = flsb_q + 1'b1;
                    ferr_d = run_inc;
                    fd_d   = 1'b1;
                    run_d  = '0;
                    if (run_inc > 20'(LOSS_THRESH)) begin
                        state_d = ACQUIRE;
                    end
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de1_q    <= 1'b0;
            de2_q    <= 1'b0;
            vs1_q    <= 1'b0;
            vs2_q    <= 1'b0;
            pix1_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            state_q  <= SEEK;
            flsb_q   <= '0;
            skip_q   <= 1'b0;
            run_q    <= '0;
            ferr_q   <= '0;
            total_q  <= '0;
            geom_q   <= 1'b0;
            fvalid_q <= 1'b0;
            fx_q     <= '0;
            fy_q     <= '0;
            fd_q     <= 1'b0;
        end else begin
            de1_q    <= pix_de;
            de2_q    <= de1_q;
            vs1_q    <= (pix_vs == VS_POL);
            vs2_q    <= vs1_q;
            pix1_q   <= '{r: pix_r, g: pix_g, b: pix_b};
            x_q      <= x_d;
            y_q      <= y_d;
            state_q  <= state_d;
            flsb_q   <= flsb_d;
            skip_q   <= skip_d;
            run_q    <= run_d;
            ferr_q   <= ferr_d;
            total_q  <= total_d;
            geom_q   <= geom_d;
            fvalid_q <= fvalid_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            fd_q     <= fd_d;
        end
    end

    assign locked        = (state_q == LOCKED);
    assign frame_done    = fd_q;
    assign frame_err_cnt = ferr_q;
    assign total_err_cnt = total_q;
    assign geom_err      = geom_q;
    assign first_err_x   = fx_q;
    assign first_err_y   = fy_q;

endmodule

// File: doc/dvi_pattern_checker.md
Name: dvi_pattern_checker

Overview:
- Receive-side counterpart of the DVI test-pattern generator: consumes the 6-bit RGB pixel stream plus DE/VSYNC after the pixel pipeline.
- Regenerates X/Y internally, locks onto the generator's frame counter, recomputes the expected pixel and counts mismatches.
- Used in loopback/capture builds to prove the pattern path bit-exact, including frame-counter tracking, line length and frame height.

Parameters:
- H_ACTIVE, 1024, active pixels per line (DE-high cycles).
- V_ACTIVE, 768, active lines per frame.
- VS_POL, 1, VSYNC active level.
- LOSS_THRESH, 16, per-frame mismatches above which lock is dropped.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_de  in  1  data enable, high during active pixels.
- pix_vs  in  1  vertical sync, level per VS_POL.
- pix_r  in  6  red.
- pix_g  in  6  green.
- pix_b  in  6  blue.
- clear  in  1  sync pulse: clears total_err_cnt, geom_err, first_err_x/y.
- locked  out  1  high in LOCKED state.
- frame_done  out  1  one-cycle pulse at each VSYNC leading edge while LOCKED.
- frame_err_cnt  out  20  mismatches in last completed frame, saturating.
- total_err_cnt  out  32  mismatches since reset/clear, saturating.
- geom_err  out  1  sticky line-length or frame-height violation.
- first_err_x  out  11  X of first mismatch since reset/clear.
- first_err_y  out  10  Y of first mismatch since reset/clear.

Behaviour:
- Reset: all outputs 0, state SEEK, X=Y=0, frame_lsb=0, first-error-valid flag clear.
- Stage 1 registers inputs. Stage 2 computes expected value and compares. Counters update 2 cycles after the pixel; frame_done is 2 cycles after the VSYNC edge.
- X/Y counters:
  - X: 11-bit, counts DE-high cycles; cleared on DE falling edge.
  - Y: 10-bit, increments on DE falling edge; cleared on VSYNC leading edge.
- Expected pixel, all sums truncated to [5:0], f = frame_lsb (6-bit):
  - Y<200: R=G=B = (X[0]^Y[0]) ? 63 : 0.
  - 200<=Y<400, X<512: R=0, G=X+f, B=0.
  - 200<=Y<400, X>=512: R=Y+f, G=0, B=0.
  - Y>=400: R=G=X[5:0], B=Y+f.
- FSM:
  - SEEK: on VSYNC leading edge go to ACQUIRE.
  - ACQUIRE: at pixel X=0,Y=200, capture frame_lsb <= pix_g, then go to LOCKED. No checking in SEEK or ACQUIRE.
  - LOCKED: every DE pixel is compared. On each VSYNC leading edge:
    - frame_lsb <= frame_lsb+1 (mod 64).
    - Latch the running count into frame_err_cnt, pulse frame_done, clear the running count.
    - If the running count > LOSS_THRESH, go to ACQUIRE (locked drops next cycle).
  - VSYNC edge and mismatch on the same cycle: the mismatch belongs to the closing frame.
- Mismatch = any channel differs.
  - Increment the running frame count and total_err_cnt, both saturating (20-bit max 0xFFFFF; 32-bit max 0xFFFFFFFF).
  - If no error is recorded since reset/clear, capture first_err_x/y.
- Geometry checks (LOCKED only):
  - DE falling edge with X != H_ACTIVE sets geom_err.
  - VSYNC leading edge with Y != V_ACTIVE sets geom_err. Skipped for the first frame after entering LOCKED.
- clear:
  - Has no effect on FSM state, frame_lsb or frame_err_cnt.
  - clear and a mismatch on the same cycle: clear wins first, then the mismatch is counted (total=1, first_err captured).
- DE high during VSYNC: pixels still counted and checked; not a geometry error.
- Async reset mid-frame returns to SEEK; no partial-frame frame_done.

Decomposition:
- Shared package dvi_pkg:
  - constants PAT_Y_CHECK_END=200, PAT_Y_SPLIT_END=400, PAT_X_SPLIT=512, PIX_W=6, X_W=11, Y_W=10.
  - checker state enum {SEEK, ACQUIRE, LOCKED}.
  - Shared with the generator so both sides stay aligned.
- One sub-module, dvi_pattern_expect: purely combinational X, Y, frame_lsb -> expected R/G/B. It is reusable as a generator reference model.

Test Plan:
- Clean stream, 1024x768 frames, generator frame=5: lock at Y=200 of frame 1 with frame_lsb=5. Next 3 frames: frame_done x3, frame_err_cnt=0, total=0, geom_err=0.
- Corrupt pix_b at X=10,Y=450 in one locked frame: frame_err_cnt=1 for that frame, first_err_x=10, first_err_y=450. Later clean frame reports 0.
- Generator frame counter crosses 63->64 and 2047->0: no errors; frame_lsb wraps 63->0.
- Skip one frame increment at the generator: every B at Y>=400 and G/R in band mismatches (>16). Lock drops (locked=0), re-acquires within one frame, then errors stop.
- One line of 1023 pixels: geom_err=1 and stays set. Pulse clear: geom_err=0, total_err_cnt=0.
- Assert rst_n low mid-frame, release mid-line: outputs 0, state SEEK, no frame_done until after relock. clear coincident with a mismatch gives total_err_cnt=1.
